// File: rtl/memalu_sched_pkg.sv
// Shared types for the MEMALU scheduler and its requesters.
// Holds the MEMALU op/control encodings and the scheduler state enum.
package memalu_sched_pkg;

  typedef enum logic [1:0] {
    MEMALU_OP_ADD    = 2'd0,
    MEMALU_OP_INCR   = 2'd1,
    MEMALU_OP_OFFSET = 2'd2
  } memalu_op_t;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } memalu_sched_state_t;

  function automatic logic op_legal(
    input memalu_op_t op
  );
    return op inside {
      MEMALU_OP_ADD,
      MEMALU_OP_INCR,
      MEMALU_OP_OFFSET
    };
  endfunction

endpackage

// File: rtl/memalu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr,
// wrapping at N. Reusable for any shared unit.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = (IW+1)'(ptr) + (IW+1)'(i);
      if (j >= (IW+1)'(N)) begin
        j = j - (IW+1)'(N);
      end
      if (!valid && req[j[IW-1:0]]) begin
        valid          = 1'b1;
        idx            = j[IW-1:0];
        gnt[j[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memalu_sched.sv
// Time-shares the MEMALU address unit between requesters and runs
// its READ/WRITE handshake, returning the result to the winner.
module memalu_sched
  import memalu_sched_pkg::*;
#(
  parameter int HALF_WIDTH = 8,
  parameter int NUM_REQ    = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0][2*HALF_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][HALF_WIDTH-1:0]     req_b,
  input  memalu_op_t [NUM_REQ-1:0]               req_op,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic                                   rsp_err,
  output logic [2*HALF_WIDTH-1:0]                rsp_data,
  output logic [2*HALF_WIDTH-1:0]                alu_a,
  output logic [HALF_WIDTH-1:0]                  alu_b,
  output memalu_op_t                             alu_mode,
  output reg_op_t                                alu_control,
  input  logic [2*HALF_WIDTH-1:0]                alu_out,
  output logic                                   busy
);

  localparam int W  = 2 * HALF_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  memalu_sched_state_t state, state_n;

  logic [NUM_REQ-1:0] gnt_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      rr_ptr;
  logic [W-1:0]       a_q;
  logic [HALF_WIDTH-1:0] b_q;
  memalu_op_t         op_q;
  logic               err_q;
  logic [W-1:0]       data_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               sel_legal;
  logic [IW-1:0]      ptr_n;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_legal = op_legal(req_op[arb_idx]);

  assign ptr_n = (idx_q == IW'(NUM_REQ - 1))
               ? '0 : idx_q + 1'b1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          state_n = sel_legal ? LOAD : DONE;
        end
      end
      LOAD:    state_n = EXEC;
      EXEC:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      idx_q  <= '0;
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MEMALU_OP_ADD;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt_q <= arb_gnt;
            idx_q <= arb_idx;
            a_q   <= req_a[arb_idx];
            b_q   <= req_b[arb_idx];
            op_q  <= req_op[arb_idx];
            err_q <= !sel_legal;
            if (!sel_legal) begin
              data_q <= '0;
            end
          end
        end
        EXEC: data_q <= alu_out;
        DONE: begin
          gnt_q  <= '0;
          err_q  <= 1'b0;
          rr_ptr <= ptr_n;
        end
        default: ;
      endcase
    end
  end

  // MEMALU only sees READ in LOAD and WRITE in EXEC
  always_comb begin
    alu_control = REG_OP_NONE;
    unique case (state)
      LOAD:    alu_control = REG_OP_READ;
      EXEC:    alu_control = REG_OP_WRITE;
      default: alu_control = REG_OP_NONE;
    endcase
  end

  assign gnt       = gnt_q;
  assign rsp_valid = (state == DONE) ? gnt_q : '0;
  assign rsp_err   = err_q;
  assign rsp_data  = data_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_mode  = op_q;
  assign busy      = (state != IDLE);

endmodule
